// File: rtl/imm_dec_ctrl.sv
// Decode-stage controller: classifies opcodes into imm_sel codes for the immediate
// generator and holds up to two decoded entries behind a registered in_ready.
module imm_dec_ctrl #(
    parameter int unsigned W  = 32,
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [W-1:0]  in_instr,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_instr,
    output logic [2:0]    out_imm_sel,
    output logic          out_illegal,
    output logic [CW-1:0] illegal_cnt
);

    localparam int unsigned SW = 3;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [W-1:0]    r_head_instr;
    logic [SW-1:0]   r_head_sel;
    logic            r_head_ill;
    logic [W-1:0]    r_skid_instr;
    logic [SW-1:0]   r_skid_sel;
    logic            r_skid_ill;
    logic [CW-1:0]   r_illegal_cnt;
    logic [SW-1:0]   w_dec_sel;
    logic            w_dec_ill;
    logic            w_push;
    logic            w_pop;

    // Opcode classification into imm_sel; unknown opcodes flag illegal with sel 000.
    always_comb begin
        w_dec_sel = 3'b000;
        w_dec_ill = 1'b0;
        case (in_instr[6:0])
            7'b0110011: w_dec_sel = 3'b000;
            7'b0010011,
            7'b0000011,
            7'b1110011: w_dec_sel = 3'b001;
            7'b1100011: w_dec_sel = 3'b010;
            7'b1101111: w_dec_sel = 3'b011;
            7'b1100111: w_dec_sel = 3'b100;
            7'b0110111,
            7'b0010111: w_dec_sel = 3'b101;
            7'b0100011: w_dec_sel = 3'b111;
            7'b0001111: w_dec_sel = 3'b000;
            default:    w_dec_ill = 1'b1;
        endcase
    end

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: if (w_push) w_state_nxt = S_ONE;
                S_ONE: begin
                    if (w_push && !w_pop)      w_state_nxt = S_TWO;
                    else if (!w_push && w_pop) w_state_nxt = S_EMPTY;
                end
                S_TWO:   if (w_pop) w_state_nxt = S_ONE;
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Handshake flags come straight from the state register, so out_ready never reaches in_ready.
    always_comb begin
        in_ready  = (r_state != S_TWO);
        out_valid = (r_state != S_EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_instr <= '0;
            r_head_sel   <= '0;
            r_head_ill   <= 1'b0;
            r_skid_instr <= '0;
            r_skid_sel   <= '0;
            r_skid_ill   <= 1'b0;
        end else if (!flush) begin
            case (r_state)
                S_EMPTY: begin
                    if (w_push) begin
                        r_head_instr <= in_instr;
                        r_head_sel   <= w_dec_sel;
                        r_head_ill   <= w_dec_ill;
                    end
                end
                S_ONE: begin
                    if (w_push && w_pop) begin
                        r_head_instr <= in_instr;
                        r_head_sel   <= w_dec_sel;
                        r_head_ill   <= w_dec_ill;
                    end else if (w_push) begin
                        r_skid_instr <= in_instr;
                        r_skid_sel   <= w_dec_sel;
                        r_skid_ill   <= w_dec_ill;
                    end
                end
                S_TWO: begin
                    if (w_pop) begin
                        r_head_instr <= r_skid_instr;
                        r_head_sel   <= r_skid_sel;
                        r_head_ill   <= r_skid_ill;
                    end
                end
                default: ;
            endcase
        end
    end

    // Saturating count of accepted illegal instructions; flush-cycle pushes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= '0;
        end else if (!flush && w_push && w_dec_ill && (r_illegal_cnt != {CW{1'b1}})) begin
            r_illegal_cnt <= r_illegal_cnt + CW'(1);
        end
    end

    assign out_instr   = r_head_instr;
    assign out_imm_sel = r_head_sel;
    assign out_illegal = r_head_ill;
    assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_imm_dec_ctrl.sv
// Directed bench for imm_dec_ctrl; a second instance with CW=2 shares the stimulus
// so counter saturation can be observed.
module tb_imm_dec_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        out_ready;
    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_instr;
    logic [2:0]  out_imm_sel;
    logic [7:0]  illegal_cnt;
    logic        in_ready2, out_valid2, out_illegal2;
    logic [31:0] out_instr2;
    logic [2:0]  out_imm_sel2;
    logic [1:0]  illegal_cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    imm_dec_ctrl #(.W(32), .CW(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_imm_sel(out_imm_sel), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt)
    );

    imm_dec_ctrl #(.W(32), .CW(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready2),
        .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
        .out_imm_sel(out_imm_sel2), .out_illegal(out_illegal2), .illegal_cnt(illegal_cnt2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic ordy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] stream [6];
    logic [2:0]  sels   [6];

    initial begin
        stream = '{32'h00000063, 32'h00112023, 32'h0000006F,
                   32'h00008067, 32'h000012B7, 32'h00000033};
        sels   = '{3'b010, 3'b111, 3'b011, 3'b100, 3'b101, 3'b000};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_instr", out_instr, 32'h0);
        chk("rst_imm_sel", 32'(out_imm_sel), 32'd0);
        chk("rst_illegal", 32'(out_illegal), 32'd0);
        chk("rst_cnt", 32'(illegal_cnt), 32'd0);
        #10 rst_n = 1'b1;

        // Single addi
        cyc(1'b1, 32'h00500093, 1'b1, 1'b0);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_instr", out_instr, 32'h00500093);
        chk("addi_sel", 32'(out_imm_sel), 32'd1);
        chk("addi_illegal", 32'(out_illegal), 32'd0);

        // Back-to-back stream, one per cycle
        foreach (stream[i]) begin
            cyc(1'b1, stream[i], 1'b1, 1'b0);
            chk($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("stream%0d_instr", i), out_instr, stream[i]);
            chk($sformatf("stream%0d_sel", i), 32'(out_imm_sel), 32'(sels[i]));
            chk($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
        end
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain_empty", 32'(out_valid), 32'd0);

        // Stall with two entries, then drain
        cyc(1'b1, 32'h00C000EF, 1'b0, 1'b0);
        chk("stall1_in_ready", 32'(in_ready), 32'd1);
        chk("stall1_instr", out_instr, 32'h00C000EF);
        cyc(1'b1, 32'h00000073, 1'b0, 1'b0);
        chk("stall2_in_ready", 32'(in_ready), 32'd0);
        chk("stall2_instr", out_instr, 32'h00C000EF);
        chk("stall2_sel", 32'(out_imm_sel), 32'd3);
        cyc(1'b1, 32'h00000033, 1'b0, 1'b0);
        chk("stall3_in_ready", 32'(in_ready), 32'd0);
        chk("stall3_instr", out_instr, 32'h00C000EF);
        chk("stall3_sel", 32'(out_imm_sel), 32'd3);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain1_instr", out_instr, 32'h00000073);
        chk("drain1_sel", 32'(out_imm_sel), 32'd1);
        chk("drain1_in_ready", 32'(in_ready), 32'd1);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("drain2_empty", 32'(out_valid), 32'd0);

        // Illegal opcodes and counter saturation on the CW=2 instance
        cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        chk("ill_flag", 32'(out_illegal), 32'd1);
        chk("ill_sel", 32'(out_imm_sel), 32'd0);
        chk("ill_cnt1", 32'(illegal_cnt), 32'd1);
        chk("ill_cnt1_cw2", 32'(illegal_cnt2), 32'd1);
        cyc(1'b1, 32'h00000000, 1'b1, 1'b0);
        chk("ill_cnt2_cw2", 32'(illegal_cnt2), 32'd2);
        cyc(1'b1, 32'h0000005B, 1'b1, 1'b0);
        chk("ill_cnt3_cw2", 32'(illegal_cnt2), 32'd3);
        cyc(1'b1, 32'h0000007F, 1'b1, 1'b0);
        chk("ill_cnt4_cw2", 32'(illegal_cnt2), 32'd3);
        cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        chk("ill_cnt5_cw2", 32'(illegal_cnt2), 32'd3);
        chk("ill_cnt5", 32'(illegal_cnt), 32'd5);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("ill_drain", 32'(out_valid), 32'd0);

        // Flush with pop from TWO
        cyc(1'b1, 32'h00000013, 1'b0, 1'b0);
        cyc(1'b1, 32'h00000023, 1'b0, 1'b0);
        chk("fl_two_in_ready", 32'(in_ready), 32'd0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        chk("fl_valid", 32'(out_valid), 32'd0);
        chk("fl_in_ready", 32'(in_ready), 32'd1);

        // Push during flush is discarded and not counted
        cyc(1'b1, 32'h00000013, 1'b0, 1'b0);
        cyc(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
        chk("flpush_valid", 32'(out_valid), 32'd0);
        chk("flpush_cnt", 32'(illegal_cnt), 32'd5);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        chk("flpush_never_out", 32'(out_valid), 32'd0);

        // Asynchronous reset between edges while holding one entry
        cyc(1'b1, 32'h00000037, 1'b0, 1'b0);
        chk("arst_pre_valid", 32'(out_valid), 32'd1);
        chk("arst_pre_sel", 32'(out_imm_sel), 32'd5);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_cnt", 32'(illegal_cnt), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_instr", out_instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b1, 32'h00000017, 1'b1, 1'b0);
        chk("post_rst_instr", out_instr, 32'h00000017);
        chk("post_rst_sel", 32'(out_imm_sel), 32'd5);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1, "timeout");
    end

endmodule
